cla_word_adder_seq: RTL and testbench

Multi-cycle WIDTH-bit adder/subtractor that sits directly upstream of the existing 4-bit carry-lookahead slice. It accepts one operand pair per transaction over a valid/ready handshake and feeds the slice one nibble per cycle, least-significant nibble first, carrying the slice's carry-out into the next nibble. It assembles the result and presents it with carry-out, signed-overflow and zero flags over a second valid/ready handshake. This gives wide additions from a single 4-bit CLA slice, trading latency for area.

---
 rtl/cla_word_adder_seq_pkg.sv | 18 +
 rtl/cla_4bit.sv | 39 +++
 rtl/cla_word_adder_seq.sv | 149 ++++++++++++++
 tb/tb_cla_word_adder_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cla_word_adder_seq_pkg.sv
// ============================================================================
// Module   : cla_word_adder_seq_pkg
// Brief    : Shared FSM encodings and slice width for the sequential CLA adder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cla_word_adder_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CLA_SLICE = 4;

endpackage

`default_nettype wire

// File: rtl/cla_4bit.sv
// ============================================================================
// Module   : cla_4bit
// Brief    : 4-bit carry-lookahead adder slice with group propagate/generate.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       pg,
    output logic       gg
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);

    assign pg   = &w_p;
    assign gg   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign cout = gg | (pg & cin);
    assign s    = w_p ^ w_c;

endmodule

`default_nettype wire

// File: rtl/cla_word_adder_seq.sv
// ============================================================================
// Module   : cla_word_adder_seq
// Brief    : WIDTH-bit add/sub built from one 4-bit CLA slice, one nibble/cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_word_adder_seq
    import cla_word_adder_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int                c_NIB      = WIDTH / CLA_SLICE;
    localparam int                c_IDXW     = (c_NIB > 1) ? $clog2(c_NIB) : 1;
    localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(c_NIB - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [c_IDXW-1:0]    r_idx;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_carry;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_cout;
    logic                 r_ovf;
    logic                 r_zero;

    logic [CLA_SLICE-1:0] w_a_nib;
    logic [CLA_SLICE-1:0] w_b_nib;
    logic [CLA_SLICE-1:0] w_s;
    logic                 w_slice_cout;
    logic                 w_slice_pg_unused;
    logic                 w_slice_gg_unused;
    logic [WIDTH-1:0]     w_sum_next;
    logic                 w_last;
    logic                 w_accept;

    assign w_a_nib  = r_a[r_idx*CLA_SLICE +: CLA_SLICE];
    assign w_b_nib  = r_b[r_idx*CLA_SLICE +: CLA_SLICE];
    assign w_last   = (r_idx == c_LAST_IDX);
    assign w_accept = in_valid && in_ready;

    cla_4bit u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_slice_cout),
        .pg   (w_slice_pg_unused),
        .gg   (w_slice_gg_unused)
    );

    // Sum with the current nibble merged in, so zero sees the final word.
    always_comb begin
        w_sum_next = r_sum;
        w_sum_next[r_idx*CLA_SLICE +: CLA_SLICE] = w_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is A + ~B + 1, so the carry register doubles as the +1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub | cin;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_slice_cout;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cout <= w_slice_cout;
                        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                  (w_s[CLA_SLICE-1] != r_a[WIDTH-1]);
                        r_zero <= (w_sum_next == '0);
                    end else begin
                        r_idx  <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_cla_word_adder_seq.sv
// ============================================================================
// Module   : tb_cla_word_adder_seq
// Brief    : Directed plus random checks of cla_word_adder_seq against a model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cla_word_adder_seq;

    localparam int c_W = 16;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           cin;
    logic           sub;
    logic           out_valid;
    logic           out_ready;
    logic [c_W-1:0] sum;
    logic           cout;
    logic           ovf;
    logic           zero;

    int n_chk = 0;
    int n_err = 0;

    cla_word_adder_seq #(.WIDTH(c_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: integer arithmetic on unsigned and signed views of the operands.
    task automatic model(input logic [c_W-1:0] ma, input logic [c_W-1:0] mb,
                         input logic mcin, input logic msub,
                         output logic [c_W-1:0] esum, output logic ecout,
                         output logic eovf, output logic ezero);
        longint ua, ub, sa, sb, ures, sres;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (msub) begin
            ures  = ua - ub;
            sres  = sa - sb;
            ecout = (ua >= ub);
        end else begin
            ures  = ua + ub + longint'(mcin);
            sres  = sa + sb + longint'(mcin);
            ecout = (ures >= 65536);
        end
        esum  = ures[c_W-1:0];
        eovf  = (sres > 32767) || (sres < -32768);
        ezero = (esum == '0);
    endtask

    // One full transaction; hold_cycles of backpressure before out_ready rises.
    task automatic run_txn(input logic [c_W-1:0] ta, input logic [c_W-1:0] tb,
                           input logic tcin, input logic tsub, input int hold_cycles);
        logic [c_W-1:0] esum;
        logic           ecout, eovf, ezero;
        int             lat;
        model(ta, tb, tcin, tsub, esum, ecout, eovf, ezero);
        check("in_ready_idle", in_ready, 1);
        out_ready = (hold_cycles == 0);
        in_valid  = 1'b1;
        a = ta; b = tb; cin = tcin; sub = tsub;
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", lat, 4);
        check("sum", sum, esum);
        check("cout", cout, ecout);
        check("ovf", ovf, eovf);
        check("zero", zero, ezero);
        if (hold_cycles > 0) begin
            for (int i = 0; i < hold_cycles; i++) begin
                in_valid = 1'b1;
                a = $urandom;
                tick();
                check("bp_out_valid", out_valid, 1);
                check("bp_in_ready", in_ready, 0);
                check("bp_sum", sum, esum);
                check("bp_flags", {cout, ovf, zero}, {ecout, eovf, ezero});
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        check("post_in_ready", in_ready, 1);
        check("post_out_valid", out_valid, 0);
        check("hold_flags_idle", {cout, ovf, zero}, {ecout, eovf, ezero});
    endtask

    initial begin
        logic [c_W-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick();
        in_valid = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_flags", {cout, ovf, zero}, 3'b000);

        run_txn(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        run_txn(16'h000F, 16'h0001, 1'b1, 1'b0, 0);
        run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_txn(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_txn(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        run_txn(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_txn(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        run_txn(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 10);

        // Abort in RUN with idx=2.
        in_valid = 1'b1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_flags", {cout, ovf, zero}, 3'b000);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_result", out_valid, 0);
        end
        run_txn(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 16'h7FFF;
                1: rb = 16'h8000;
                2: rb = ra;
                3: ra = 16'hFFFF;
                default: ;
            endcase
            run_txn(ra, rb, 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 7) == 0) ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
